// File: rtl/patch_mac_scheduler.sv
// Patch MAC scheduler: loads an N_TAPS kernel into kbuf, streams one patch at a time to the
// MAC pipeline and writes the returned sum to the result FIFO. Define PATCH_SCHED_RELU_EN to clamp negative results to 0.
module patch_mac_scheduler #(
  parameter int unsigned N_TAPS = 81
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  output logic        kernel_rden,
  input  logic [31:0] kernel_data,
  input  logic        kernel_empty,
  input  logic        kernel_open,
  output logic        patch_rden,
  input  logic [31:0] patch_data,
  input  logic        patch_empty,
  input  logic        patch_open,
  output logic        result_wren,
  output logic [31:0] result_data,
  input  logic        result_full,
  output logic        mac_valid,
  output logic [31:0] mac_kernel,
  output logic [31:0] mac_pixel,
  output logic        mac_first,
  output logic        mac_last,
  input  logic        mac_res_valid,
  input  logic [31:0] mac_res,
  output logic        busy,
  output logic        kernel_loaded,
  output logic [15:0] patch_count
);
  localparam int unsigned TAP_W = 8;
  localparam int unsigned IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);
  localparam logic [TAP_W-1:0] N_TAPS_W = TAP_W'(N_TAPS);

  typedef enum logic [2:0] {IDLE, LOAD_K, RUN, WAIT, WRITE} state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TAP_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               k_pop_q, p_pop_q;
  logic               loaded_d;
  logic [15:0]        count_d;
  logic               wren_d;
  logic [31:0]        rdata_d;
  logic               kbuf_we;
  logic [31:0]        kbuf [N_TAPS];

  function automatic logic [31:0] shape_res(input logic [31:0] r);
`ifdef PATCH_SCHED_RELU_EN
    return r[31] ? 32'd0 : r;
`else
    return r;
`endif
  endfunction

  // Operands issue in the cycle the popped patch word is on patch_data
  assign mac_valid  = p_pop_q && (state_q == RUN) && patch_open;
  assign mac_pixel  = mac_valid ? patch_data : 32'd0;
  assign mac_kernel = mac_valid ? kbuf[IDX_W'(tap_q)] : 32'd0;
  assign mac_first  = mac_valid && (tap_q == '0);
  assign mac_last   = mac_valid && (tap_q == LAST_TAP);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    rd_cnt_d    = rd_cnt_q;
    loaded_d    = kernel_loaded;
    count_d     = patch_count;
    wren_d      = 1'b0;
    rdata_d     = result_data;
    kbuf_we     = 1'b0;
    kernel_rden = 1'b0;
    patch_rden  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!kernel_loaded && kernel_open && !kernel_empty) begin
          state_d = LOAD_K;
        end else if (kernel_loaded && kernel_open && !patch_empty && !result_full) begin
          state_d = RUN;
        end
      end
      LOAD_K: begin
        // rd_cnt counts pops, tap counts stored words (one cycle behind)
        kernel_rden = kernel_open && !kernel_empty && (rd_cnt_q < N_TAPS_W);
        if (kernel_rden) rd_cnt_d = rd_cnt_q + TAP_W'(1);
        if (k_pop_q) begin
          kbuf_we = 1'b1;
          tap_d   = tap_q + TAP_W'(1);
          if (tap_q == LAST_TAP) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
            tap_d    = '0;
            rd_cnt_d = '0;
          end
        end
        if (!kernel_open) begin
          kbuf_we  = 1'b0;
          state_d  = IDLE;
          tap_d    = '0;
          rd_cnt_d = '0;
        end
      end
      RUN: begin
        patch_rden = patch_open && !patch_empty && (rd_cnt_q < N_TAPS_W);
        if (patch_rden) rd_cnt_d = rd_cnt_q + TAP_W'(1);
        if (mac_valid) begin
          tap_d = tap_q + TAP_W'(1);
          if (tap_q == LAST_TAP) begin
            state_d  = WAIT;
            tap_d    = '0;
            rd_cnt_d = '0;
          end
        end
        if (!patch_open) begin
          state_d  = IDLE;
          tap_d    = '0;
          rd_cnt_d = '0;
        end
      end
      WAIT: begin
        if (mac_res_valid) begin
          rdata_d = shape_res(mac_res);
          if (!result_full) begin
            wren_d  = 1'b1;
            count_d = patch_count + 16'd1;
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // result_data already holds the sum; only the write strobe waits for space
        if (!result_full) begin
          wren_d  = 1'b1;
          count_d = patch_count + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!kernel_open) loaded_d = 1'b0;
    if (bus_rst) begin
      kernel_rden = 1'b0;
      patch_rden  = 1'b0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q       <= IDLE;
      tap_q         <= '0;
      rd_cnt_q      <= '0;
      k_pop_q       <= 1'b0;
      p_pop_q       <= 1'b0;
      kernel_loaded <= 1'b0;
      patch_count   <= '0;
      result_wren   <= 1'b0;
      result_data   <= '0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      rd_cnt_q      <= rd_cnt_d;
      k_pop_q       <= kernel_rden;
      p_pop_q       <= patch_rden;
      kernel_loaded <= loaded_d;
      patch_count   <= count_d;
      result_wren   <= wren_d;
      result_data   <= rdata_d;
    end
  end

  // Kernel storage has no reset; it is only read after a complete load
  always_ff @(posedge bus_clk) begin
    if (kbuf_we) kbuf[IDX_W'(tap_q)] <= kernel_data;
  end

endmodule

// File: tb/tb_patch_mac_scheduler.sv
// Directed bench for patch_mac_scheduler (N_TAPS=9) with FIFO and summing-pipeline models.
`timescale 1ns/1ps
module tb_patch_mac_scheduler;
  localparam int unsigned N = 9;

  logic        bus_clk = 1'b0;
  logic        bus_rst = 1'b1;
  logic        kernel_rden, patch_rden, result_wren;
  logic [31:0] kernel_data = '0, patch_data = '0, result_data;
  logic        kernel_empty = 1'b1, patch_empty = 1'b1;
  logic        kernel_open = 1'b1, patch_open = 1'b1, result_full = 1'b0;
  logic        mac_valid, mac_first, mac_last;
  logic [31:0] mac_kernel, mac_pixel;
  logic        mac_res_valid = 1'b0;
  logic [31:0] mac_res = '0;
  logic        busy, kernel_loaded;
  logic [15:0] patch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] kq[$];
  logic [31:0] pq[$];
  logic [65:0] mac_log[$];
  logic [31:0] res_log[$];
  logic [31:0] kexp [N];
  logic [31:0] acc = '0;
  int          res_dly = 0;

  patch_mac_scheduler #(.N_TAPS(N)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .kernel_rden(kernel_rden), .kernel_data(kernel_data),
    .kernel_empty(kernel_empty), .kernel_open(kernel_open),
    .patch_rden(patch_rden), .patch_data(patch_data),
    .patch_empty(patch_empty), .patch_open(patch_open),
    .result_wren(result_wren), .result_data(result_data), .result_full(result_full),
    .mac_valid(mac_valid), .mac_kernel(mac_kernel), .mac_pixel(mac_pixel),
    .mac_first(mac_first), .mac_last(mac_last),
    .mac_res_valid(mac_res_valid), .mac_res(mac_res),
    .busy(busy), .kernel_loaded(kernel_loaded), .patch_count(patch_count)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Standard-read FIFOs: data appears the cycle after rden
  always @(posedge bus_clk) begin
    if (kernel_rden && kq.size() > 0) kernel_data <= kq.pop_front();
    if (patch_rden && pq.size() > 0) patch_data <= pq.pop_front();
    kernel_empty <= (kq.size() == 0);
    patch_empty  <= (pq.size() == 0);
  end

  // Summing pipeline, operand log, result log and FIFO protocol watch
  always @(posedge bus_clk) begin
    #1;
    chk("rden_while_empty", 66'((kernel_rden && kernel_empty) || (patch_rden && patch_empty)), 66'd0);
    if (mac_valid) begin
      mac_log.push_back({mac_first, mac_last, mac_kernel, mac_pixel});
      acc = mac_first ? mac_kernel * mac_pixel : acc + mac_kernel * mac_pixel;
      if (mac_last) res_dly = 3;
    end
    mac_res_valid = 1'b0;
    if (res_dly == 1) begin
      mac_res_valid = 1'b1;
      mac_res       = acc;
    end
    if (res_dly > 0) res_dly--;
    if (bus_rst) res_dly = 0;
    if (result_wren) res_log.push_back(result_data);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic wait_loaded(input string tag);
    int i = 0;
    while (kernel_loaded !== 1'b1 && i < 300) begin @(negedge bus_clk); i++; end
    chk(tag, 66'(kernel_loaded), 66'd1);
  endtask

  task automatic wait_macs(input int n, input string tag);
    int i = 0;
    while (mac_log.size() < n && i < 300) begin @(negedge bus_clk); i++; end
    chk(tag, 66'(mac_log.size() >= n), 66'd1);
  endtask

  task automatic wait_res(input int n, input string tag);
    int i = 0;
    while (res_log.size() < n && i < 300) begin @(negedge bus_clk); i++; end
    chk(tag, 66'(res_log.size() >= n), 66'd1);
  endtask

  task automatic load_kernel(input bit ramp, input logic [31:0] val);
    for (int i = 0; i < N; i++) begin
      kexp[i] = ramp ? 32'(i + 1) : val;
      kq.push_back(kexp[i]);
    end
  endtask

  task automatic push_patch(input int from, input int to);
    for (int i = from; i <= to; i++) pq.push_back(32'(i));
  endtask

  // Expected operand stream: pixel ramp 1..N against kexp, first/last on the end taps
  task automatic chk_macs(input string tag);
    chk({tag, "_mac_count"}, 66'(mac_log.size()), 66'(N));
    for (int i = 0; i < N && i < mac_log.size(); i++) begin
      chk($sformatf("%s_mac%0d", tag, i), mac_log[i],
          {1'(i == 0), 1'(i == N - 1), kexp[i], 32'(i + 1)});
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_flags", 66'({busy, kernel_loaded, kernel_rden, patch_rden, result_wren, mac_valid}), 66'd0);
    chk("rst_count", 66'(patch_count), 66'd0);
    chk("rst_rdata", 66'(result_data), 66'd0);
    bus_rst = 1'b0;

    // Kernel 1..9, patch 1..9 -> sum of squares 285
    load_kernel(1'b1, 32'd0);
    wait_loaded("s1_load_wait");
    cyc(1);
    chk("s1_idle_after_load", 66'(busy), 66'd0);
    mac_log.delete();
    push_patch(1, 9);
    wait_res(1, "s1_res_wait");
    cyc(1);
    chk("s1_result", 66'(res_log[0]), 66'd285);
    chk("s1_count", 66'(patch_count), 66'd1);
    chk_macs("s1");

    // Three empty cycles after word 4
    mac_log.delete();
    push_patch(1, 4);
    wait_macs(4, "s2_macs_wait");
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk($sformatf("s2_gap%0d_no_mac", i), 66'(mac_valid), 66'd0);
    end
    push_patch(5, 9);
    wait_res(2, "s2_res_wait");
    cyc(1);
    chk("s2_result", 66'(res_log[1]), 66'd285);
    chk("s2_count", 66'(patch_count), 66'd2);
    chk_macs("s2");

    // Result FIFO full when the sum returns, released after 5 cycles
    mac_log.delete();
    push_patch(1, 9);
    wait_macs(9, "s3_macs_wait");
    result_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk($sformatf("s3_full%0d_no_wren", i), 66'(result_wren), 66'd0);
    end
    chk("s3_held_busy", 66'(busy), 66'd1);
    result_full = 1'b0;
    wait_res(3, "s3_res_wait");
    chk("s3_result", 66'(res_log[2]), 66'd285);
    cyc(10);
    chk("s3_single_write", 66'(res_log.size()), 66'd3);
    chk("s3_count", 66'(patch_count), 66'd3);

    // Kernel closed after 5 words, then reloaded with all 2s -> 2*45 = 90
    kernel_open = 1'b0;
    cyc(1);
    chk("s4_unloaded", 66'(kernel_loaded), 66'd0);
    kernel_open = 1'b1;
    for (int i = 0; i < 5; i++) kq.push_back(32'd7);
    cyc(12);
    chk("s4_stalled_in_load", 66'(busy), 66'd1);
    kernel_open = 1'b0;
    cyc(1);
    chk("s4_abort_idle", 66'({busy, kernel_loaded}), 66'd0);
    kernel_open = 1'b1;
    load_kernel(1'b0, 32'd2);
    wait_loaded("s4_load_wait");
    mac_log.delete();
    push_patch(1, 9);
    wait_res(4, "s4_res_wait");
    cyc(1);
    chk("s4_result", 66'(res_log[3]), 66'd90);
    chk("s4_count", 66'(patch_count), 66'd4);
    chk_macs("s4");

    // Reset while RUN sits at tap 5
    mac_log.delete();
    push_patch(1, 5);
    wait_macs(5, "s5_macs_wait");
    cyc(1);
    bus_rst = 1'b1;
    cyc(1);
    chk("s5_rst_flags", 66'({busy, kernel_loaded, kernel_rden, patch_rden, result_wren,
                              mac_valid, mac_first, mac_last}), 66'd0);
    chk("s5_rst_mac_bus", 66'({mac_kernel, mac_pixel}), 66'd0);
    chk("s5_rst_count", 66'(patch_count), 66'd0);
    chk("s5_rst_rdata", 66'(result_data), 66'd0);
    bus_rst = 1'b0;
    cyc(20);
    chk("s5_no_result", 66'(res_log.size()), 66'd4);
    chk("s5_no_more_macs", 66'(mac_log.size()), 66'd5);

    // Kernel all -1, patch 1..9 -> -45, or 0 with ReLU
    load_kernel(1'b0, 32'hFFFF_FFFF);
    wait_loaded("s6_load_wait");
    mac_log.delete();
    push_patch(1, 9);
    wait_res(5, "s6_res_wait");
    cyc(1);
`ifdef PATCH_SCHED_RELU_EN
    chk("s6_result", 66'(res_log[4]), 66'd0);
`else
    chk("s6_result", 66'(res_log[4]), 66'h0_FFFF_FFD3);
`endif
    chk("s6_count", 66'(patch_count), 66'd1);
    chk_macs("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
